// File: rtl/nonce_arbiter.sv
// Golden-nonce collector: per-slave holding registers, round-robin grant into a
// small result FIFO, and a transmit sequencer driving the shared serial uplink.
module nonce_arbiter #(
    parameter int SLAVES    = 5,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic [SLAVES-1:0]    new_nonces,
    input  logic [SLAVES*32-1:0] slave_nonces,
    input  logic                 serial_busy,
    output logic                 serial_send,
    output logic [31:0]          golden_nonce,
    output logic [SLAVES-1:0]    pending,
    output logic [7:0]           dropped
);
    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int PTR_W  = FIFO_LOG2 + 1;
    localparam int IDX_W  = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam int CNT_W  = $clog2(SLAVES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;
    state_t state;

    logic [31:0]       hold     [SLAVES];
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [IDX_W-1:0]  rr, grant_idx;
    logic              grant_vld, fifo_full, fifo_empty;
    logic [SLAVES-1:0] grant_oh, drop_vec;

    function automatic logic [CNT_W-1:0] count_ones(input logic [SLAVES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SLAVES; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CNT_W-1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + 9'(b);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                        (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);

    // Round-robin search starting at rr; full is judged on registered pointers only.
    always_comb begin
        logic [IDX_W1-1:0] j;
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = '0;
        for (int k = 0; k < SLAVES; k++) begin
            j = {1'b0, rr} + IDX_W1'(k);
            if (j >= IDX_W1'(SLAVES)) j = j - IDX_W1'(SLAVES);
            if (!fifo_full && !grant_vld && pending[j[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        drop_vec = '0;
        for (int i = 0; i < SLAVES; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == IDX_W'(i));
            drop_vec[i] = pending[i] && new_nonces[i] && !grant_oh[i];
        end
    end

    // Holding-stage control: a same-cycle grant frees the slot, so a refill is not a drop.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            dropped <= '0;
            rr      <= '0;
            wr_ptr  <= '0;
        end else begin
            pending <= (pending & ~grant_oh) | new_nonces;
            dropped <= sat_add8(dropped, count_ones(drop_vec));
            if (grant_vld) begin
                rr     <= (grant_idx == IDX_W'(SLAVES - 1)) ? '0 : grant_idx + IDX_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) hold[i] <= slave_nonces[i*32 +: 32];
        end
        if (grant_vld) fifo_mem[wr_ptr[FIFO_LOG2-1:0]] <= hold[grant_idx];
    end

    // Transmit sequencer: golden_nonce only changes in IDLE, so it holds for the whole frame.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            serial_send  <= 1'b0;
            golden_nonce <= '0;
            rd_ptr       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    serial_send <= 1'b0;
                    if (!fifo_empty) begin
                        golden_nonce <= fifo_mem[rd_ptr[FIFO_LOG2-1:0]];
                        rd_ptr       <= rd_ptr + PTR_W'(1);
                        serial_send  <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    serial_send <= 1'b0;
                    state       <= WAIT_HI;
                end
                WAIT_HI: if (serial_busy) state <= WAIT_LO;
                WAIT_LO: if (!serial_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_arbiter.sv
// Scoreboard bench for nonce_arbiter with a simple serial_transmit model.
module tb_nonce_arbiter;
    localparam int SLAVES    = 5;
    localparam int FIFO_LOG2 = 2;
    localparam int FRAME     = 6;

    logic                 hash_clk = 1'b0;
    logic                 reset = 1'b1;
    logic [SLAVES-1:0]    new_nonces = '0;
    logic [SLAVES*32-1:0] slave_nonces = '0;
    logic                 serial_busy;
    logic                 serial_send;
    logic [31:0]          golden_nonce;
    logic [SLAVES-1:0]    pending;
    logic [7:0]           dropped;

    logic hold_busy = 1'b0;
    logic tx_busy   = 1'b0;
    int   tx_cnt    = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   send_cnt  = 0;
    logic [31:0] exp_q[$];

    assign serial_busy = hold_busy | tx_busy;

    nonce_arbiter #(.SLAVES(SLAVES), .FIFO_LOG2(FIFO_LOG2)) dut (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .new_nonces  (new_nonces),
        .slave_nonces(slave_nonces),
        .serial_busy (serial_busy),
        .serial_send (serial_send),
        .golden_nonce(golden_nonce),
        .pending     (pending),
        .dropped     (dropped)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Transmitter: busy rises the cycle after send and lasts FRAME cycles; ignores reset.
    always @(posedge hash_clk) begin
        if (serial_send) begin
            tx_busy <= 1'b1;
            tx_cnt  <= FRAME;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_busy <= 1'b0;
        end
    end

    always @(negedge hash_clk) begin
        if (!reset && serial_send) begin
            send_cnt++;
            if (exp_q.size() == 0) check("unexpected_send", 32'd1, 32'd0);
            else check("golden_nonce", golden_nonce, exp_q.pop_front());
        end
    end

    task automatic set_val(input int s, input logic [31:0] v);
        slave_nonces[s*32 +: 32] = v;
    endtask

    task automatic drive(input logic [SLAVES-1:0] mask);
        new_nonces = mask;
        @(negedge hash_clk);
        new_nonces = '0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge hash_clk);
            i++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge hash_clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 40 && tx_busy; i++) @(negedge hash_clk);
        reset      = 1'b1;
        hold_busy  = 1'b0;
        new_nonces = '0;
        @(negedge hash_clk);
        exp_q.delete();
        @(negedge hash_clk);
        reset = 1'b0;
    endtask

    // Leaves the FSM stuck in WAIT_LO and the FIFO holding four entries.
    task automatic fill_blocked();
        hold_busy = 1'b1;
        set_val(0, 32'hF000_0000);
        exp_q.push_back(32'hF000_0000);
        drive(5'b00001);
        repeat (6) @(negedge hash_clk);
        set_val(2, 32'hF000_0002); set_val(3, 32'hF000_0003);
        set_val(4, 32'hF000_0004); set_val(0, 32'hF000_0010);
        exp_q.push_back(32'hF000_0002); exp_q.push_back(32'hF000_0003);
        exp_q.push_back(32'hF000_0004); exp_q.push_back(32'hF000_0010);
        drive(5'b11101);
        repeat (8) @(negedge hash_clk);
        check("fill_pending", 32'(pending), 32'd0);
    endtask

    initial begin
        int sends_before;
        @(negedge hash_clk);
        check("rst_send", 32'(serial_send), 32'd0);
        check("rst_golden", golden_nonce, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        reset = 1'b0;
        @(negedge hash_clk);

        // Single nonce: three-cycle latency, one-cycle send pulse
        do_reset();
        set_val(2, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        drive(5'b00100);
        check("t1_pending", 32'(pending), 32'h4);
        check("t1_send_c1", 32'(serial_send), 32'd0);
        @(negedge hash_clk);
        check("t1_send_c2", 32'(serial_send), 32'd0);
        @(negedge hash_clk);
        check("t1_send_c3", 32'(serial_send), 32'd1);
        check("t1_golden", golden_nonce, 32'hDEADBEEF);
        @(negedge hash_clk);
        check("t1_send_c4", 32'(serial_send), 32'd0);
        wait_drain(100);
        check("t1_dropped", 32'(dropped), 32'd0);

        // All five slaves at once, rr = 0
        do_reset();
        for (int i = 0; i < SLAVES; i++) begin
            set_val(i, 32'((i + 1) * 17));
            exp_q.push_back(32'((i + 1) * 17));
        end
        drive('1);
        wait_drain(300);
        check("t2_dropped", 32'(dropped), 32'd0);
        check("t2_pending", 32'(pending), 32'd0);

        // Same-cycle grant and refill on slave 0
        do_reset();
        set_val(0, 32'hA);
        exp_q.push_back(32'hA);
        drive(5'b00001);
        set_val(0, 32'hB);
        exp_q.push_back(32'hB);
        drive(5'b00001);
        wait_drain(200);
        check("t3_dropped", 32'(dropped), 32'd0);

        // Backpressure: FIFO full, slave 1 overwritten twice
        do_reset();
        fill_blocked();
        set_val(1, 32'hC1); drive(5'b00010);
        set_val(1, 32'hC2); drive(5'b00010);
        set_val(1, 32'hC3); exp_q.push_back(32'hC3); drive(5'b00010);
        @(negedge hash_clk);
        check("t4_pending", 32'(pending), 32'h2);
        check("t4_dropped", 32'(dropped), 32'd2);
        hold_busy = 1'b0;
        wait_drain(400);
        check("t4_dropped_end", 32'(dropped), 32'd2);

        // Saturation of the drop counter
        do_reset();
        fill_blocked();
        for (int i = 0; i < 300; i++) begin
            set_val(1, 32'h1000 + i);
            drive(5'b00010);
        end
        exp_q.push_back(32'h1000 + 299);
        check("t5_dropped", 32'(dropped), 32'd255);
        check("t5_pending", 32'(pending), 32'h2);
        hold_busy = 1'b0;
        wait_drain(400);
        check("t5_dropped_end", 32'(dropped), 32'd255);

        // Reset while in WAIT_LO with three entries queued
        do_reset();
        for (int i = 0; i < 4; i++) set_val(i, 32'h60 + i);
        exp_q.push_back(32'h60);
        drive(5'b01111);
        for (int i = 0; i < 20 && !serial_send; i++) @(negedge hash_clk);
        check("t6_first_send", 32'(serial_send), 32'd1);
        repeat (3) @(negedge hash_clk);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_send", 32'(serial_send), 32'd0);
        check("t6_rst_golden", golden_nonce, 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        check("t6_rst_dropped", 32'(dropped), 32'd0);
        exp_q.delete();
        @(negedge hash_clk);
        reset = 1'b0;
        sends_before = send_cnt;
        repeat (40) @(negedge hash_clk);
        check("t6_no_send", 32'(send_cnt - sends_before), 32'd0);
        set_val(4, 32'h77);
        exp_q.push_back(32'h77);
        drive(5'b10000);
        wait_drain(100);
        check("t6_new_send", 32'(send_cnt - sends_before), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
